// File: rtl/count_capture_fifo.sv
// count_capture_fifo: snapshots a free-running counter on a strobe, tags each
// snapshot with a wrap tally and buffers it in a small valid/ready FIFO.
module count_capture_fifo #(
   parameter int CNT_W  = 6,
   parameter int DEPTH  = 4,
   parameter int WRAP_W = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [CNT_W-1:0]           count_in,
   input  logic                       capture,
   input  logic                       clr_overflow,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CNT_W-1:0]           out_count,
   output logic [WRAP_W-1:0]          out_wraps,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty,
   output logic                       overflow
);
   localparam int AW = $clog2(DEPTH);

   logic [CNT_W-1:0]  r_mem_cnt [DEPTH];
   logic [WRAP_W-1:0] r_mem_wrp [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_level;
   logic [WRAP_W-1:0] r_wraps;
   logic [CNT_W-1:0]  r_prev;
   logic              r_ovf;

   logic              w_wrap_evt;
   logic [WRAP_W-1:0] w_wrap_next;
   logic              w_push;
   logic              w_pop;
   logic              w_drop;

   // Wrap is only the all-ones to zero step; other decreases are ignored.
   // Head outputs read zero when nothing is stored.
   always_comb begin
      w_wrap_evt  = (r_prev == '1) && (count_in == '0);
      w_wrap_next = r_wraps + WRAP_W'(w_wrap_evt);
      empty       = (r_level == '0);
      full        = (r_level == (AW+1)'(DEPTH));
      out_valid   = !empty;
      w_pop       = out_valid && out_ready;
      w_push      = capture && (!full || w_pop);
      w_drop      = capture && full && !w_pop;
      out_count   = empty ? '0 : r_mem_cnt[r_rptr];
      out_wraps   = empty ? '0 : r_mem_wrp[r_rptr];
      level       = r_level;
      overflow    = r_ovf;
   end

   // Storage slots need no reset; only pointers and level decide validity.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_cnt[r_wptr] <= count_in;
         r_mem_wrp[r_wptr] <= w_wrap_next;
      end
   end

   // Pointers, level, wrap tally and sticky overflow; drop beats clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
         r_wraps <= '0;
         r_prev  <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_prev  <= count_in;
         r_wraps <= w_wrap_next;
         r_wptr  <= w_push ? r_wptr + 1'b1 : r_wptr;
         r_rptr  <= w_pop ? r_rptr + 1'b1 : r_rptr;
         r_level <= (w_push && !w_pop) ? r_level + 1'b1 :
                    (w_pop && !w_push) ? r_level - 1'b1 : r_level;
         r_ovf   <= w_drop ? 1'b1 : (clr_overflow ? 1'b0 : r_ovf);
      end
   end
endmodule
